// File: rtl/cg_sense_cond.sv
// Two-channel photogate conditioner: synchronise, polarity-correct and qualify raw
// sensor lines into fixed-width pulses with lockout, and time trigger-to-gate transit.
module cg_sense_cond #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PULSE_W     = 4,
    parameter int unsigned TW          = 24
) (
    input  logic          clk,
    input  logic          I_RST,
    input  logic          I_S_TRIG,
    input  logic          I_S_GATE,
    input  logic [1:0]    I_POL,
    input  logic [7:0]    I_FLT,
    input  logic [15:0]   I_LOCK,
    input  logic          I_EN,
    output logic          O_TRIG,
    output logic          O_GATE,
    output logic [TW-1:0] O_TT,
    output logic          O_TTV,
    output logic          O_TOVF,
    output logic          O_BUSY
);

    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
    localparam logic [TW-1:0] TMAX = '1;

    typedef enum logic [1:0] {IDLE, QUAL, FIRE, LOCK} ch_state_t;
    typedef enum logic {T_IDLE, T_RUN} t_state_t;

    logic [1:0] raw;
    logic [1:0] fire_go;
    logic [1:0] pulse;

    assign raw = {I_S_GATE, I_S_TRIG};

    // Channel 0 = trigger, channel 1 = gate; identical qualification pipelines.
    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        ch_state_t              st;
        logic [CW-1:0]          cnt;
        logic                   pulse_q;
        logic                   active;

        assign active     = sync[SYNC_STAGES-1] ^ ~I_POL[c];
        // Same condition as the QUAL->FIRE transition, exported for the transit timer.
        assign fire_go[c] = (st == QUAL) && I_EN && active && (cnt >= CW'(I_FLT));
        assign pulse[c]   = pulse_q;

        always_ff @(posedge clk or posedge I_RST) begin
            if (I_RST) begin
                sync    <= '0;
                st      <= IDLE;
                cnt     <= '0;
                pulse_q <= 1'b0;
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], raw[c]};
                case (st)
                    IDLE: begin
                        if (I_EN && active) begin
                            st  <= QUAL;
                            cnt <= CW'(1);
                        end
                    end
                    QUAL: begin
                        if (!I_EN || !active) begin
                            st  <= IDLE;
                            cnt <= '0;
                        end else if (cnt >= CW'(I_FLT)) begin
                            st      <= FIRE;
                            cnt     <= '0;
                            pulse_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    FIRE: begin
                        if (cnt == PULSE_LAST) begin
                            st      <= LOCK;
                            cnt     <= '0;
                            pulse_q <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    LOCK: begin
                        // Re-arm only once the line has gone inactive, so a held sensor fires once.
                        if ((cnt >= I_LOCK) && !active) begin
                            st  <= IDLE;
                            cnt <= '0;
                        end else if (cnt != '1) begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        st      <= IDLE;
                        cnt     <= '0;
                        pulse_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign O_TRIG = pulse[0];
    assign O_GATE = pulse[1];

    t_state_t        t_st;
    logic [TW-1:0]   tcnt;
    logic [TW-1:0]   tcnt_inc;

    // The capture stores the count including the stop cycle, i.e. fire-to-fire distance.
    assign tcnt_inc = (tcnt == TMAX) ? tcnt : tcnt + TW'(1);

    // Transit timer: trigger fire starts/restarts, gate fire captures.
    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            t_st   <= T_IDLE;
            tcnt   <= '0;
            O_TT   <= '0;
            O_TTV  <= 1'b0;
            O_TOVF <= 1'b0;
            O_BUSY <= 1'b0;
        end else begin
            case (t_st)
                T_IDLE: begin
                    if (fire_go[0]) begin
                        t_st   <= T_RUN;
                        tcnt   <= '0;
                        O_BUSY <= 1'b1;
                        O_TTV  <= 1'b0;
                        O_TOVF <= 1'b0;
                    end
                end
                T_RUN: begin
                    if (fire_go[1]) begin
                        O_TT  <= tcnt_inc;
                        O_TTV <= 1'b1;
                    end
                    if (fire_go[0]) begin
                        tcnt   <= '0;
                        O_TOVF <= 1'b0;
                        if (!fire_go[1]) begin
                            O_TTV <= 1'b0;
                        end
                    end else begin
                        tcnt <= tcnt_inc;
                        if (tcnt_inc == TMAX) begin
                            O_TOVF <= 1'b1;
                        end
                        if (fire_go[1]) begin
                            t_st   <= T_IDLE;
                            O_BUSY <= 1'b0;
                        end
                    end
                end
                default: begin
                    t_st   <= T_IDLE;
                    O_BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cg_sense_cond.sv
// Directed bench for cg_sense_cond: pulse shaping, glitch rejection, polarity, enable,
// transit timing with a 24-bit and an 8-bit timer instance, and mid-pulse reset.
module tb_cg_sense_cond;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_trig;
    logic        s_gate;
    logic [1:0]  pol;
    logic [7:0]  flt;
    logic [15:0] lock;
    logic        en;

    logic        trig_o, gate_o, ttv, tovf, busy;
    logic [23:0] tt;
    logic        trig8, gate8, ttv8, tovf8, busy8;
    logic [7:0]  tt8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cg_sense_cond #(.SYNC_STAGES(2), .PULSE_W(4), .TW(24)) dut (
        .clk(clk), .I_RST(rst), .I_S_TRIG(s_trig), .I_S_GATE(s_gate), .I_POL(pol),
        .I_FLT(flt), .I_LOCK(lock), .I_EN(en), .O_TRIG(trig_o), .O_GATE(gate_o),
        .O_TT(tt), .O_TTV(ttv), .O_TOVF(tovf), .O_BUSY(busy)
    );

    cg_sense_cond #(.SYNC_STAGES(2), .PULSE_W(4), .TW(8)) dut8 (
        .clk(clk), .I_RST(rst), .I_S_TRIG(s_trig), .I_S_GATE(s_gate), .I_POL(pol),
        .I_FLT(flt), .I_LOCK(lock), .I_EN(en), .O_TRIG(trig8), .O_GATE(gate8),
        .O_TT(tt8), .O_TTV(ttv8), .O_TOVF(tovf8), .O_BUSY(busy8)
    );

    task automatic test_reset();
        rst = 1'b1; s_trig = 1'b0; s_gate = 1'b0; pol = 2'b11;
        flt = 8'd5; lock = 16'd10; en = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (trig_o !== 1'b0) begin bad++; $display("FAIL reset_trig got=%b exp=0", trig_o); end
        total++; if (gate_o !== 1'b0) begin bad++; $display("FAIL reset_gate got=%b exp=0", gate_o); end
        total++; if (tt !== 24'd0) begin bad++; $display("FAIL reset_tt got=%0d exp=0", tt); end
        total++; if ({ttv, tovf, busy} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {ttv, tovf, busy}); end
        total++; if ({tt8, ttv8, tovf8, busy8} !== 11'd0) begin bad++; $display("FAIL reset_dut8 got=%h exp=0", {tt8, ttv8, tovf8, busy8}); end
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_hold();
        int rise = -1, width = 0, rises = 0, ghigh = 0;
        logic prev = 1'b0;
        @(negedge clk); s_trig = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 20) s_trig = 1'b0;
            if (trig_o && !prev) begin rises++; if (rise < 0) rise = k; end
            if (trig_o) width++;
            if (gate_o) ghigh++;
            prev = trig_o;
        end
        total++; if (rise != 8) begin bad++; $display("FAIL hold_latency got=%0d exp=8", rise); end
        total++; if (width != 4) begin bad++; $display("FAIL hold_width got=%0d exp=4", width); end
        total++; if (rises != 1) begin bad++; $display("FAIL hold_single got=%0d exp=1", rises); end
        total++; if (ghigh != 0) begin bad++; $display("FAIL hold_gate_quiet got=%0d exp=0", ghigh); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_busy got=%b exp=1", busy); end
    endtask

    task automatic test_glitch();
        int highs = 0;
        for (int r = 0; r < 10; r++) begin
            @(negedge clk); s_trig = 1'b1;
            for (int k = 0; k < 3; k++) begin @(negedge clk); if (trig_o) highs++; end
            s_trig = 1'b0;
            for (int k = 0; k < 5; k++) begin @(negedge clk); if (trig_o) highs++; end
        end
        for (int k = 0; k < 10; k++) begin @(negedge clk); if (trig_o) highs++; end
        total++; if (highs != 0) begin bad++; $display("FAIL glitch_reject got=%0d exp=0", highs); end
    endtask

    task automatic test_transit();
        @(negedge clk); s_trig = 1'b1;
        for (int k = 1; k <= 1040; k++) begin
            @(negedge clk);
            if (k == 20) s_trig = 1'b0;
            if (k == 1000) s_gate = 1'b1;
            if (k == 1020) s_gate = 1'b0;
            if (k == 500) begin
                total++; if ({busy, ttv} !== 2'b10) begin bad++; $display("FAIL transit_mid got=%b exp=10", {busy, ttv}); end
            end
            if (k == 1007) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL transit_busy_pre got=%b exp=1", busy); end
            end
            if (k == 1008) begin
                total++; if ({busy, gate_o} !== 2'b01) begin bad++; $display("FAIL transit_stop got=%b exp=01", {busy, gate_o}); end
            end
        end
        total++; if (tt !== 24'd1000) begin bad++; $display("FAIL transit_tt got=%0d exp=1000", tt); end
        total++; if ({ttv, tovf} !== 2'b10) begin bad++; $display("FAIL transit_flags got=%b exp=10", {ttv, tovf}); end
        total++; if (tt8 !== 8'd255) begin bad++; $display("FAIL transit_tt8 got=%0d exp=255", tt8); end
        total++; if ({ttv8, tovf8} !== 2'b11) begin bad++; $display("FAIL transit_flags8 got=%b exp=11", {ttv8, tovf8}); end
    endtask

    task automatic test_overflow();
        @(negedge clk); s_trig = 1'b1;
        for (int k = 1; k <= 270; k++) begin
            @(negedge clk);
            if (k == 20) s_trig = 1'b0;
            if (k == 262) begin
                total++; if ({tovf8, busy8} !== 2'b01) begin bad++; $display("FAIL ovf_pre got=%b exp=01", {tovf8, busy8}); end
            end
            if (k == 263) begin
                total++; if ({tovf8, busy8, ttv8} !== 3'b110) begin bad++; $display("FAIL ovf_set got=%b exp=110", {tovf8, busy8, ttv8}); end
                total++; if (tt8 !== 8'd255) begin bad++; $display("FAIL ovf_tt_hold got=%0d exp=255", tt8); end
                total++; if ({tovf, busy} !== 2'b01) begin bad++; $display("FAIL ovf_wide got=%b exp=01", {tovf, busy}); end
            end
        end
    endtask

    task automatic test_pol_en();
        int trise = -1, thigh = 0, ghigh = 0, quiet = 0;
        logic prev = 1'b0;
        en = 1'b0;
        @(negedge clk); pol = 2'b00; s_trig = 1'b1; s_gate = 1'b1;
        repeat (10) @(negedge clk);
        en = 1'b1;
        repeat (3) @(negedge clk);
        s_trig = 1'b0; s_gate = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 8) begin s_trig = 1'b1; s_gate = 1'b1; end
            if (trig_o && !prev && trise < 0) trise = k;
            if (trig_o) thigh++;
            if (gate_o) ghigh++;
            prev = trig_o;
        end
        total++; if (trise != 8) begin bad++; $display("FAIL pol_latency got=%0d exp=8", trise); end
        total++; if (thigh != 4) begin bad++; $display("FAIL pol_trig_width got=%0d exp=4", thigh); end
        total++; if (ghigh != 4) begin bad++; $display("FAIL pol_gate_width got=%0d exp=4", ghigh); end
        total++; if ({busy, ttv} !== 2'b11) begin bad++; $display("FAIL pol_simul_run got=%b exp=11", {busy, ttv}); end
        total++; if ({busy8, ttv8, tt8} !== {2'b11, 8'd255}) begin bad++; $display("FAIL pol_simul_run8 got=%h exp=3ff", {busy8, ttv8, tt8}); end
        en = 1'b0;
        repeat (2) @(negedge clk);
        s_trig = 1'b0; s_gate = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 8) begin s_trig = 1'b1; s_gate = 1'b1; end
            if (trig_o || gate_o) quiet++;
        end
        total++; if (quiet != 0) begin bad++; $display("FAIL en_block got=%0d exp=0", quiet); end
        @(negedge clk); pol = 2'b11; s_trig = 1'b0; s_gate = 1'b0;
        repeat (10) @(negedge clk);
        en = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int grise = -1, ghigh = 0, grises = 0;
        logic prev = 1'b0;
        @(negedge clk); s_gate = 1'b1;
        repeat (9) @(negedge clk);
        total++; if ({gate_o, ttv} !== 2'b11) begin bad++; $display("FAIL rstmid_pre got=%b exp=11", {gate_o, ttv}); end
        rst = 1'b1;
        #1;
        total++; if ({gate_o, gate8} !== 2'b00) begin bad++; $display("FAIL rstmid_drop got=%b exp=00", {gate_o, gate8}); end
        total++; if ({ttv, busy, tt} !== 26'd0) begin bad++; $display("FAIL rstmid_timer got=%h exp=0", {ttv, busy, tt}); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 30) s_gate = 1'b0;
            if (gate_o && !prev) begin grises++; if (grise < 0) grise = k; end
            if (gate_o) ghigh++;
            prev = gate_o;
        end
        total++; if (grise != 8) begin bad++; $display("FAIL rstmid_latency got=%0d exp=8", grise); end
        total++; if ({grises, ghigh} != {32'd1, 32'd4}) begin bad++; $display("FAIL rstmid_pulse got=%0d/%0d exp=1/4", grises, ghigh); end
        total++; if ({busy, ttv, tt} !== 26'd0) begin bad++; $display("FAIL rstmid_gate_idle got=%h exp=0", {busy, ttv, tt}); end
    endtask

    task automatic test_min_filter();
        for (int i = 0; i < 2; i++) begin
            int rise = -1, highs = 0;
            logic prev = 1'b0;
            flt = 8'(i);
            repeat (2) @(negedge clk);
            s_trig = 1'b1;
            for (int k = 1; k <= 30; k++) begin
                @(negedge clk);
                if (k == 10) s_trig = 1'b0;
                if (trig_o && !prev && rise < 0) rise = k;
                if (trig_o) highs++;
                prev = trig_o;
            end
            total++; if (rise != 4) begin bad++; $display("FAIL minflt%0d_latency got=%0d exp=4", i, rise); end
            total++; if (highs != 4) begin bad++; $display("FAIL minflt%0d_width got=%0d exp=4", i, highs); end
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_glitch();
        test_transit();
        test_overflow();
        test_pol_en();
        test_reset_mid();
        test_min_filter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
